// File: rtl/vc_mchan_queue.sv
// Purpose: p_num_chans independent FIFO channels, p_num_msgs deep each, behind one
//          channel-tagged enqueue port and one round-robin arbitrated dequeue port.
// Latency: one cycle from an accepted enqueue to the earliest presentation on deq; no bypass.
// Backpressure: enq_rdy drops when the addressed channel is full, or when enq_chan is
//          out of range. With p_pipe_en=1, a full channel that is being dequeued in the
//          same cycle still accepts. deq_val/deq_chan/deq_msg hold steady while deq_rdy=0,
//          unless a higher-priority channel fills.
// Ports:   clk, reset (async active-low); enq_val/enq_rdy/enq_chan/enq_msg;
//          deq_val/deq_rdy/deq_chan/deq_msg; num_free_entries (per channel, ch0 in LSBs).
// Option:  VC_MCHAN_QUEUE_SCRUB_EN resets the storage and zeroes each slot as it is dequeued.
module vc_mchan_queue #(
   parameter int p_msg_nbits  = 32,
   parameter int p_num_msgs   = 4,
   parameter int p_num_chans  = 2,
   parameter int p_pipe_en    = 0,
   localparam int c_addr_nbits = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1,
   localparam int c_chan_nbits = $clog2(p_num_chans)
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     enq_val,
   output logic                                     enq_rdy,
   input  logic [c_chan_nbits-1:0]                  enq_chan,
   input  logic [p_msg_nbits-1:0]                   enq_msg,
   output logic                                     deq_val,
   input  logic                                     deq_rdy,
   output logic [c_chan_nbits-1:0]                  deq_chan,
   output logic [p_msg_nbits-1:0]                   deq_msg,
   output logic [p_num_chans*(c_addr_nbits+1)-1:0]  num_free_entries
);

   localparam int                    c_cnt_nbits = c_addr_nbits + 1;
   localparam logic [c_cnt_nbits-1:0]  c_full      = c_cnt_nbits'(p_num_msgs);
   localparam logic [c_addr_nbits-1:0] c_last_slot = c_addr_nbits'(p_num_msgs - 1);
   localparam logic [c_chan_nbits-1:0] c_last_chan = c_chan_nbits'(p_num_chans - 1);
   localparam bit                    c_pipe      = (p_pipe_en != 0);

   logic [c_addr_nbits-1:0] enq_ptr [p_num_chans];
   logic [c_addr_nbits-1:0] deq_ptr [p_num_chans];
   logic [c_cnt_nbits-1:0]  count   [p_num_chans];
   logic [c_chan_nbits-1:0] rr_ptr;
   logic [p_msg_nbits-1:0]  storage [p_num_chans][p_num_msgs];

   logic [c_chan_nbits-1:0] grant;
   logic [c_chan_nbits-1:0] idx;
   logic                    any_vld;
   logic                    enq_chan_ok;
   logic [c_cnt_nbits-1:0]  enq_cnt;
   logic                    do_enq;
   logic                    do_deq;
   logic [p_num_chans-1:0]  enq_hit;
   logic [p_num_chans-1:0]  deq_hit;

   function automatic logic [c_addr_nbits-1:0] ptr_inc(input logic [c_addr_nbits-1:0] p);
      return (p == c_last_slot) ? '0 : p + 1'b1;
   endfunction

   // Cyclic search starting at rr_ptr; the first non-empty channel wins.
   always_comb begin
      grant   = '0;
      any_vld = 1'b0;
      idx     = '0;
      for (int i = 0; i < p_num_chans; i++) begin
         idx = c_chan_nbits'((int'(rr_ptr) + i) % p_num_chans);
         if (!any_vld && (count[idx] != '0)) begin
            any_vld = 1'b1;
            grant   = idx;
         end
      end
   end

   assign deq_val  = any_vld;
   assign deq_chan = any_vld ? grant : '0;
   assign deq_msg  = any_vld ? storage[grant][deq_ptr[grant]] : '0;
   assign do_deq   = deq_val && deq_rdy;

   // Out-of-range channels read as full so they can never be accepted.
   assign enq_chan_ok = (int'(enq_chan) < p_num_chans);
   assign enq_cnt     = enq_chan_ok ? count[enq_chan] : c_full;
   assign enq_rdy     = enq_chan_ok &&
                        ((enq_cnt < c_full) || (c_pipe && do_deq && (grant == enq_chan)));
   assign do_enq      = enq_val && enq_rdy;

   always_comb begin
      enq_hit          = '0;
      deq_hit          = '0;
      num_free_entries = '0;
      for (int c = 0; c < p_num_chans; c++) begin
         enq_hit[c] = do_enq && (int'(enq_chan) == c);
         deq_hit[c] = do_deq && (int'(grant) == c);
         num_free_entries[c*c_cnt_nbits +: c_cnt_nbits] = c_full - count[c];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
         for (int c = 0; c < p_num_chans; c++) begin
            enq_ptr[c] <= '0;
            deq_ptr[c] <= '0;
            count[c]   <= '0;
         end
      end else begin
         if (do_deq) begin
            rr_ptr <= (grant == c_last_chan) ? '0 : grant + 1'b1;
         end
         for (int c = 0; c < p_num_chans; c++) begin
            if (enq_hit[c]) enq_ptr[c] <= ptr_inc(enq_ptr[c]);
            if (deq_hit[c]) deq_ptr[c] <= ptr_inc(deq_ptr[c]);
            // Same-channel enq+deq leaves count alone, including the full pipe case.
            if (enq_hit[c] && !deq_hit[c]) count[c] <= count[c] + 1'b1;
            else if (deq_hit[c] && !enq_hit[c]) count[c] <= count[c] - 1'b1;
         end
      end
   end

`ifdef VC_MCHAN_QUEUE_SCRUB_EN
   // Enqueue is written last so pipe-mode data into the just-freed slot beats the scrub.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < p_num_chans; c++) begin
            for (int m = 0; m < p_num_msgs; m++) begin
               storage[c][m] <= '0;
            end
         end
      end else begin
         if (do_deq) storage[grant][deq_ptr[grant]] <= '0;
         if (do_enq) storage[enq_chan][enq_ptr[enq_chan]] <= enq_msg;
      end
   end
`else
   // Plain RAM: stale words stay behind but the deq_msg gating never exposes them.
   always_ff @(posedge clk) begin
      if (do_enq) storage[enq_chan][enq_ptr[enq_chan]] <= enq_msg;
   end
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset) begin
         assert (!$isunknown(enq_val));
         assert (!$isunknown(deq_rdy));
         if (enq_val) assert (!$isunknown(enq_chan));
      end
   end
`endif

endmodule

// File: tb/tb_vc_mchan_queue.sv
// Purpose: directed bench for vc_mchan_queue; three instances cover the default build,
//          a 3-deep wrap case and pipe mode. Inputs change 1ns after the rising edge,
//          outputs are compared 2ns later.
module tb_vc_mchan_queue;

   logic        clk;
   logic        reset;
   logic        enq_val  [3];
   logic        deq_rdy  [3];
   logic [0:0]  enq_chan [3];
   logic [31:0] enq_msg  [3];
   logic        enq_rdy  [3];
   logic        deq_val  [3];
   logic [0:0]  deq_chan [3];
   logic [31:0] deq_msg  [3];
   logic [5:0]  nfe      [3];

   int checks   = 0;
   int failures = 0;

   // inst 0: 4 deep, no pipe; inst 1: 3 deep; inst 2: 4 deep, pipe mode
   vc_mchan_queue #(.p_msg_nbits(32), .p_num_msgs(4), .p_num_chans(2), .p_pipe_en(0)) dut0 (
      .clk(clk), .reset(reset),
      .enq_val(enq_val[0]), .enq_rdy(enq_rdy[0]), .enq_chan(enq_chan[0]), .enq_msg(enq_msg[0]),
      .deq_val(deq_val[0]), .deq_rdy(deq_rdy[0]), .deq_chan(deq_chan[0]), .deq_msg(deq_msg[0]),
      .num_free_entries(nfe[0]));

   vc_mchan_queue #(.p_msg_nbits(32), .p_num_msgs(3), .p_num_chans(2), .p_pipe_en(0)) dut1 (
      .clk(clk), .reset(reset),
      .enq_val(enq_val[1]), .enq_rdy(enq_rdy[1]), .enq_chan(enq_chan[1]), .enq_msg(enq_msg[1]),
      .deq_val(deq_val[1]), .deq_rdy(deq_rdy[1]), .deq_chan(deq_chan[1]), .deq_msg(deq_msg[1]),
      .num_free_entries(nfe[1]));

   vc_mchan_queue #(.p_msg_nbits(32), .p_num_msgs(4), .p_num_chans(2), .p_pipe_en(1)) dut2 (
      .clk(clk), .reset(reset),
      .enq_val(enq_val[2]), .enq_rdy(enq_rdy[2]), .enq_chan(enq_chan[2]), .enq_msg(enq_msg[2]),
      .deq_val(deq_val[2]), .deq_rdy(deq_rdy[2]), .deq_chan(deq_chan[2]), .deq_msg(deq_msg[2]),
      .num_free_entries(nfe[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int i = 0; i < 3; i++) begin
         enq_val[i]  = 1'b0;
         deq_rdy[i]  = 1'b0;
         enq_chan[i] = 1'b0;
         enq_msg[i]  = 32'h0;
      end
   endtask

   // Pulse reset between edges; called 1ns after an edge.
   task automatic do_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic put(input int i, input logic [0:0] ch, input logic [31:0] m);
      enq_val[i] = 1'b1; enq_chan[i] = ch; enq_msg[i] = m;
      #2;
      chk($sformatf("put_rdy_i%0d_%0h", i, m), {63'h0, enq_rdy[i]}, 64'h1);
      step();
      enq_val[i] = 1'b0;
   endtask

   // {deq_val, deq_chan, deq_msg}
   function automatic logic [63:0] dq(input int i);
      return {30'h0, deq_val[i], deq_chan[i], deq_msg[i]};
   endfunction

   function automatic logic [63:0] exp_dq(input logic v, input logic [0:0] ch, input logic [31:0] m);
      return {30'h0, v, ch, m};
   endfunction

   logic [0:0]  seq_ch  [4];
   logic [31:0] seq_msg [4];

   initial begin
      idle_all();
      reset = 1'b0;
      #3;
      chk("rst_deq",     dq(0), exp_dq(1'b0, 1'b0, 32'h0));
      chk("rst_free",    {58'h0, nfe[0]}, 64'h24);
      chk("rst_enq_rdy", {63'h0, enq_rdy[0]}, 64'h1);
      chk("rst_free_i1", {58'h0, nfe[1]}, 64'h1B);
      #9 reset = 1'b1;
      step();
      chk("idle_deq", dq(0), exp_dq(1'b0, 1'b0, 32'h0));

      // Fill ch0 with the consumer stalled, then probe full and the other channel.
      for (int k = 0; k < 4; k++) put(0, 1'b0, 32'h11 * (k + 1));
      enq_val[0] = 1'b1; enq_chan[0] = 1'b0; enq_msg[0] = 32'h55;
      #2;
      chk("full_enq_rdy", {63'h0, enq_rdy[0]}, 64'h0);
      chk("full_free",    {58'h0, nfe[0]}, 64'h20);
      step();
      put(0, 1'b1, 32'hAA);
      #2;
      chk("ch1_free",     {58'h0, nfe[0]}, 64'h18);
      chk("stall_head",   dq(0), exp_dq(1'b1, 1'b0, 32'h11));
      step();
      chk("stall_hold",   dq(0), exp_dq(1'b1, 1'b0, 32'h11));

      // Drain: rr alternates, skipping ch1 once it empties.
      deq_rdy[0] = 1'b1;
      #2;
      chk("drain0", dq(0), exp_dq(1'b1, 1'b0, 32'h11)); step();
      chk("drain1", dq(0), exp_dq(1'b1, 1'b1, 32'hAA)); step();
      chk("drain2", dq(0), exp_dq(1'b1, 1'b0, 32'h22)); step();
      chk("drain3", dq(0), exp_dq(1'b1, 1'b0, 32'h33)); step();
      chk("drain4", dq(0), exp_dq(1'b1, 1'b0, 32'h44)); step();
      chk("drain_empty", dq(0), exp_dq(1'b0, 1'b0, 32'h0));
      chk("drain_free",  {58'h0, nfe[0]}, 64'h24);
      deq_rdy[0] = 1'b0;

      // Interleaved round-robin from a fresh rr pointer.
      do_reset();
      step();
      put(0, 1'b0, 32'h11); put(0, 1'b1, 32'hA1);
      put(0, 1'b0, 32'h22); put(0, 1'b1, 32'hA2);
      seq_ch[0] = 1'b0; seq_msg[0] = 32'h11;
      seq_ch[1] = 1'b1; seq_msg[1] = 32'hA1;
      seq_ch[2] = 1'b0; seq_msg[2] = 32'h22;
      seq_ch[3] = 1'b1; seq_msg[3] = 32'hA2;
      deq_rdy[0] = 1'b1;
      #2;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr%0d", k), dq(0), exp_dq(1'b1, seq_ch[k], seq_msg[k]));
         step();
         #2;
      end
      chk("rr_empty", dq(0), exp_dq(1'b0, 1'b0, 32'h0));
      deq_rdy[0] = 1'b0;

      // Wrap: 10 back-to-back enq/deq pairs on ch1 of the 3-deep instance.
      step();
      deq_rdy[1] = 1'b1; enq_val[1] = 1'b1; enq_chan[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         enq_msg[1] = 32'hB0 + k;
         #2;
         if (k == 0) begin
            chk("wrap_first_nobypass", dq(1), exp_dq(1'b0, 1'b0, 32'h0));
            chk("wrap_first_free",     {58'h0, nfe[1]}, 64'h1B);
         end else begin
            chk($sformatf("wrap%0d", k), dq(1), exp_dq(1'b1, 1'b1, 32'hB0 + k - 1));
            chk($sformatf("wrap_free%0d", k), {58'h0, nfe[1]}, 64'h13);
         end
         step();
      end
      enq_val[1] = 1'b0;
      #2;
      chk("wrap_last",  dq(1), exp_dq(1'b1, 1'b1, 32'hB9));
      step();
      #2;
      chk("wrap_empty", dq(1), exp_dq(1'b0, 1'b0, 32'h0));
      chk("wrap_free",  {58'h0, nfe[1]}, 64'h1B);
      deq_rdy[1] = 1'b0;

      // Full channel with a same-cycle dequeue: pipe instance accepts, plain one does not.
      do_reset();
      step();
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 3; i += 2) begin
            enq_val[i] = 1'b1; enq_chan[i] = 1'b0; enq_msg[i] = 32'h11 * (k + 1);
         end
         step();
      end
      for (int i = 0; i < 3; i += 2) begin
         enq_msg[i] = 32'h55; deq_rdy[i] = 1'b1;
      end
      #2;
      chk("pipe_enq_rdy",    {63'h0, enq_rdy[2]}, 64'h1);
      chk("nopipe_enq_rdy",  {63'h0, enq_rdy[0]}, 64'h0);
      chk("pipe_head",       dq(2), exp_dq(1'b1, 1'b0, 32'h11));
      step();
      enq_val[0] = 1'b0; enq_val[2] = 1'b0;
      deq_rdy[0] = 1'b0; deq_rdy[2] = 1'b0;
      #2;
      chk("pipe_free_full",  {58'h0, nfe[2]}, 64'h20);
      chk("nopipe_free",     {58'h0, nfe[0]}, 64'h21);
      deq_rdy[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("pipe_order%0d", k), dq(2),
             exp_dq(1'b1, 1'b0, (k == 3) ? 32'h55 : 32'h11 * (k + 2)));
         step();
         #2;
      end
      chk("pipe_empty", dq(2), exp_dq(1'b0, 1'b0, 32'h0));
      deq_rdy[2] = 1'b0;

      // Async reset between edges with 3 entries queued.
      do_reset();
      step();
      put(0, 1'b0, 32'h1); put(0, 1'b0, 32'h2); put(0, 1'b1, 32'h3);
      #2;
      chk("pre_areset", dq(0), exp_dq(1'b1, 1'b0, 32'h1));
      #1 reset = 1'b0;
      #1;
      chk("areset_deq",  dq(0), exp_dq(1'b0, 1'b0, 32'h0));
      chk("areset_free", {58'h0, nfe[0]}, 64'h24);
`ifdef VC_MCHAN_QUEUE_SCRUB_EN
      for (int c = 0; c < 2; c++) begin
         for (int m = 0; m < 4; m++) begin
            chk($sformatf("scrub_c%0d_m%0d", c, m), {32'h0, dut0.storage[c][m]}, 64'h0);
         end
      end
`endif
      #1 reset = 1'b1;
      step();
      #2;
      chk("post_areset_deq", dq(0), exp_dq(1'b0, 1'b0, 32'h0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vc_mchan_queue.md
Name: vc_mchan_queue

Overview:
- Multi-channel successor to the single-channel valid/ready queue.
- Holds p_num_chans independent FIFO channels, each p_num_msgs deep, behind one shared enqueue port (channel-tagged) and one shared dequeue port.
- Dequeue picks among non-empty channels by round-robin.
- Sits between per-domain producers (e.g. NoC/cache request sources) and a single consumer; each channel's data never overtakes or mixes with another's.

Parameters:
- p_msg_nbits, 32, message width in bits
- p_num_msgs, 4, entries per channel; any value >=1, not required to be a power of two
- p_num_chans, 2, number of channels, >=2
- p_pipe_en, 0, 1 = full channel accepts an enqueue in the same cycle it is dequeued
- c_addr_nbits, $clog2(p_num_msgs) (min 1), local, entry index width
- c_chan_nbits, $clog2(p_num_chans), local, channel id width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- enq_val  in  1  enqueue request valid
- enq_rdy  out  1  selected channel can accept
- enq_chan  in  c_chan_nbits  target channel of enqueue
- enq_msg  in  p_msg_nbits  enqueue payload
- deq_val  out  1  some channel non-empty; deq_msg/deq_chan valid
- deq_rdy  in  1  consumer accepts
- deq_chan  out  c_chan_nbits  channel of the presented message
- deq_msg  out  p_msg_nbits  presented payload
- num_free_entries  out  p_num_chans*(c_addr_nbits+1)  per-channel free count, channel 0 in LSBs

Behaviour:
- State per channel:
  - enq_ptr and deq_ptr, each wrapping from p_num_msgs-1 to 0.
  - count, 0..p_num_msgs.
- Shared state: round-robin pointer rr_ptr (c_chan_nbits).
- Reset asserted (reset==0), asynchronously:
  - all ptrs, counts and rr_ptr = 0.
  - outputs: deq_val=0, deq_chan=0, deq_msg=0, enq_rdy=1 (if enq_chan is in range), num_free_entries = p_num_msgs in every field.
  - Reset mid-operation discards all queued messages.
- Transfers: do_enq = enq_val && enq_rdy; do_deq = deq_val && deq_rdy.
- Enqueue:
  - enq_rdy = (count[enq_chan] < p_num_msgs) || (p_pipe_en && do_deq && grant == enq_chan).
  - enq_chan >= p_num_chans gives enq_rdy=0; the request is ignored.
  - Data is written to slot enq_ptr[enq_chan] at the edge.
- Dequeue latency: a message enqueued at edge N is first presentable in the cycle after edge N. There is no bypass; an empty channel never presents same-cycle enq data.
- Grant:
  - Combinational: the first channel with count!=0 searching cyclically from rr_ptr.
  - deq_val = any count!=0; deq_chan = grant; deq_msg = storage[grant][deq_ptr[grant]].
  - When deq_val=0, deq_msg and deq_chan are forced to 0 (no stale data exposed).
- On do_deq: deq_ptr[grant] advances and rr_ptr <= (grant+1) mod p_num_chans. Without do_deq, rr_ptr holds, so a stalled consumer sees a stable deq_chan/deq_msg unless a higher-priority channel fills.
- Simultaneous enq and deq on the same channel: count unchanged, both pointers advance. Different channels update independently.
- Full pipe case (p_pipe_en=1, count==p_num_msgs, dequeuing that channel): the write goes to the just-freed slot (enq_ptr==deq_ptr); count stays p_num_msgs.
- num_free_entries[c] = p_num_msgs - count[c], combinational from registered count.
- Per-channel FIFO order is strict; no cross-channel reordering guarantee beyond round-robin.
- Assertion (sim only, when reset==1): enq_val, deq_rdy, enq_chan (when enq_val) never X.

Optional Feature:
- Macro: VC_MCHAN_QUEUE_SCRUB_EN.
- Defined:
  - Storage entries are also cleared to 0 by reset.
  - On each do_deq, the dequeued slot is overwritten with 0 at the same edge, unless a pipe-mode enqueue writes that slot in the same cycle (enqueue data wins).
  - Guarantees no residual message bits remain after dequeue.
- Undefined:
  - Storage has no reset and is not cleared on dequeue; stale data stays in RAM but is never driven out (deq_msg gating still applies).

Test Plan:
- Reset then idle: deq_val=0, deq_msg=0, num_free_entries={4,4} for p_num_msgs=4, p_num_chans=2; enq_rdy=1 for enq_chan=0.
- Fill ch0 with 0x11,0x22,0x33,0x44 while deq_rdy=0:
  - 5th enq to ch0 gives enq_rdy=0; ch0 free=0.
  - Enq 0xAA to ch1 is still accepted; ch1 free=3.
- With ch0={0x11,0x22}, ch1={0xA1,0xA2}, deq_rdy=1 every cycle: deq sequence is (0,0x11),(1,0xA1),(0,0x22),(1,0xA2), then deq_val=0.
- Wrap: 10 back-to-back enq/deq pairs on ch1 with p_num_msgs=3: the outputs equal the inputs in order; count never exceeds 1; pointers wrap cleanly.
- p_pipe_en=1, ch0 full, deq_rdy=1 with grant=0, enq_val=1 to ch0 with 0x55: enq_rdy=1, ch0 free stays 0, and 0x55 is dequeued 4th in order.
- Async reset pulsed mid-traffic (between edges) with 3 entries queued: deq_val drops to 0 immediately and free=p_num_msgs on all channels. With VC_MCHAN_QUEUE_SCRUB_EN, a hierarchical peek shows all storage = 0.
